// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready
// requesters. A grant lasts up to MAX_BURST beats, writes are gated on the
// FIFO full flag, and the FIFO's wr_ack/overflow returns are monitored with
// sticky error flags.
module fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned FIFO_WIDTH = 16,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_wr_en,
    output logic [FIFO_WIDTH-1:0]         fifo_data_in,
    input  logic                          fifo_full,
    input  logic                          fifo_wr_ack,
    input  logic                          fifo_overflow,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy,
    output logic [15:0]                   beat_total,
    output logic                          ack_err,
    output logic                          ovf_err
);

    localparam int unsigned IDW = $clog2(NUM_REQ);
    localparam int unsigned BCW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(MAX_BURST - 1);
    localparam logic [IDW-1:0] LAST_ID   = IDW'(NUM_REQ - 1);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t         state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] winner;
    logic [IDW-1:0] next_ptr;
    logic           any_valid;
    logic [BCW-1:0] beat_cnt;
    logic           xfer;
    logic           ack_pending;

    // Pick the first valid requester at or above rr_ptr, wrapping around.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        winner    = '0;
        any_valid = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(rr_ptr) + k) % NUM_REQ;
            if (!any_valid && req_valid[idx]) begin
                winner    = IDW'(idx);
                any_valid = 1'b1;
            end
        end
    end

    // Only the granted requester sees ready, and only while the FIFO has room.
    always_comb begin
        req_ready = '0;
        if (state == BURST) begin
            req_ready[grant_id] = !fifo_full;
        end
    end

    assign busy         = (state == BURST);
    assign xfer         = busy && req_valid[grant_id] && !fifo_full;
    assign fifo_wr_en   = xfer;
    assign fifo_data_in = req_data[grant_id*FIFO_WIDTH +: FIFO_WIDTH];
    assign next_ptr     = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;

    // Arbitration FSM: grant in IDLE, count beats in BURST, rotate priority on exit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        grant_id <= winner;
                        beat_cnt <= '0;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    // A full-stall (valid high, no transfer) keeps the burst alive.
                    if ((xfer && beat_cnt == LAST_BEAT) || !req_valid[grant_id]) begin
                        rr_ptr <= next_ptr;
                        state  <= IDLE;
                    end else if (xfer) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Beat counter and sticky checks of the FIFO's registered returns.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_total  <= '0;
            ack_pending <= 1'b0;
            ack_err     <= 1'b0;
            ovf_err     <= 1'b0;
        end else begin
            if (xfer) begin
                beat_total <= beat_total + 16'd1;
            end
            ack_pending <= xfer;
            if (fifo_wr_ack != ack_pending) begin
                ack_err <= 1'b1;
            end
            if (fifo_overflow) begin
                ovf_err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter that shares one synchronous FIFO write port among NUM_REQ requesters.
- Each requester uses a valid/ready handshake. A grant is held for a burst of up to MAX_BURST beats.
- Writes are gated on the FIFO's combinational full flag, so the FIFO never overflows.
- The registered wr_ack and overflow returns from the FIFO are checked, and sticky error flags are raised on any protocol mismatch.

Parameters:
- NUM_REQ, 4: number of requesters; must be ≥2.
- FIFO_WIDTH, 16: data width per beat.
- MAX_BURST, 4: maximum beats per grant; must be ≥1.

Ports:
- clk, in, 1: rising-edge clock.
- rst, in, 1: asynchronous, active-high reset.
- req_valid, in, NUM_REQ: bit i set means requester i has a beat.
- req_data, in, NUM_REQ*FIFO_WIDTH: requester i data in slice [i*FIFO_WIDTH +: FIFO_WIDTH].
- req_ready, out, NUM_REQ: bit i set means a beat from requester i is accepted this cycle.
- fifo_wr_en, out, 1: FIFO write enable.
- fifo_data_in, out, FIFO_WIDTH: FIFO write data.
- fifo_full, in, 1: FIFO full flag (combinational from count).
- fifo_wr_ack, in, 1: FIFO write acknowledge, registered, one cycle after an accepted write.
- fifo_overflow, in, 1: FIFO overflow flag, registered.
- grant_id, out, $clog2(NUM_REQ): index of the current or last granted requester.
- busy, out, 1: high in state BURST.
- beat_total, out, 16: total beats written, wrapping.
- ack_err, out, 1: sticky; wr_ack protocol mismatch.
- ovf_err, out, 1: sticky; overflow seen.

Behaviour:
- Reset (async, immediate):
  - state = IDLE; rr_ptr = 0, so requester 0 has highest priority.
  - grant_id = 0; beat_cnt = 0; beat_total = 0; ack_pending = 0; ack_err = 0; ovf_err = 0.
  - req_ready, fifo_wr_en and busy go low combinationally.
- States: IDLE and BURST.
- IDLE:
  - If any req_valid is set, select the first valid index searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - On the next edge: grant_id = winner, beat_cnt = 0, state = BURST.
  - The fifo_full level does not affect arbitration.
- BURST:
  - req_ready[grant_id] = !fifo_full; all other ready bits are 0.
  - A transfer occurs when req_valid[grant_id] and req_ready[grant_id] are both high.
  - fifo_wr_en = transfer.
  - fifo_data_in = data slice of grant_id. It is a combinational mux and is don't-care when fifo_wr_en is low.
- Burst end, checked at each edge in BURST:
  - If a transfer occurs and beat_cnt == MAX_BURST-1: go to IDLE.
  - Else if req_valid[grant_id] is low: go to IDLE.
  - Else if a transfer occurs: beat_cnt increments and the FSM stays in BURST.
  - Else (stalled on full): stay in BURST with beat_cnt unchanged. A stall never ends a burst.
  - On every exit to IDLE: rr_ptr = (grant_id+1) mod NUM_REQ.
- Latency and throughput:
  - First write occurs one cycle after valid is seen in IDLE.
  - Throughput is 1 beat/cycle within a burst.
  - There is one IDLE bubble cycle between bursts.
- Requester rule: data must be held stable while valid is high and ready is low. Dropping valid before ready is permitted and ends the burst.
- beat_total increments by 1 per transfer and wraps from 0xFFFF to 0.
- Ack check:
  - ack_pending <= fifo_wr_en each cycle.
  - ack_err is set if fifo_wr_ack differs from ack_pending in any cycle.
  - ack_err is cleared only by rst.
- ovf_err is set on any cycle with fifo_overflow high and is cleared only by rst.
- Simultaneous events:
  - Full and the last beat together: no transfer, so the burst continues.
  - Valid drop and full together: the burst ends.
- Reset mid-burst: any write in flight that has not yet been clocked is dropped; no partial state survives.

Test Plan:
1. Only req 2 valid, 6 beats (0xA000..0xA005), FIFO empty, MAX_BURST=4 → req 2 wins twice: beats A000..A003 on consecutive cycles, one IDLE bubble, then A004..A005; beat_total=6; grant_id=2.
2. All 4 reqs valid continuously, 2 beats each → grant order 0,1,2,3, with each burst ending after the requester's 2nd beat when its valid drops; FIFO read order is 0,0,1,1,2,2,3,3.
3. FIFO_DEPTH=8, req 0 streams 10 beats with no reads → 8 writes, then ready=0 while full; fifo_overflow is never seen; ovf_err=0; after 2 reads, the remaining 2 beats are written.
4. Drive fifo_wr_ack=1 in a cycle following no write → ack_err=1 next cycle and stays 1 until rst.
5. Assert rst during the 2nd beat of a req 1 burst → same-cycle: fifo_wr_en=0, busy=0, all outputs at reset values; after release with req 3 valid, req 0 has priority over req 3 if both are valid.
